// File: rtl/hi_lo_multiply_divide_unit.sv
// Execute-stage HI/LO unit.
// Runs iterative MULT/MULTU/DIV/DIVU (32 iterations plus a sign-fix cycle) and single-cycle
// MTHI/MTLO, and owns the architectural HI and LO registers. While an iterative operation is
// in flight it stalls the Decode->Execute register.
module hi_lo_multiply_divide_unit #(
  parameter int unsigned ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  ALU_function_execute,
  input  logic        HI_register_write_execute,
  input  logic        LO_register_write_execute,
  input  logic [31:0] src_A_execute,
  input  logic [31:0] src_B_execute,
  output logic        stall_execute,
  output logic        busy,
  output logic [31:0] HI_register_read_data,
  output logic [31:0] LO_register_read_data
);

  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  localparam logic [4:0] LastIter = 5'(ITERATIONS - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  // MUL: {partial product, remaining multiplier bits}. DIV: [31:0] holds dividend/quotient.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        is_div_q, is_div_d;

  logic        is_mul_op, is_div_op, is_signed_op, start;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift, rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_mul_op    = (ALU_function_execute == FnMult) || (ALU_function_execute == FnMultu);
  assign is_div_op    = (ALU_function_execute == FnDiv) || (ALU_function_execute == FnDivu);
  assign is_signed_op = (ALU_function_execute == FnMult) || (ALU_function_execute == FnDiv);
  assign start        = (state_q == StIdle) && HI_register_write_execute &&
                        LO_register_write_execute && (is_mul_op || is_div_op);

  assign abs_a = (is_signed_op && src_A_execute[31]) ? -src_A_execute : src_A_execute;
  assign abs_b = (is_signed_op && src_B_execute[31]) ? -src_B_execute : src_B_execute;

  // One shift-add step: add multiplicand into the upper half when the low multiplier bit is set.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);

  // One restoring-division step; rem_diff[32] set means the trial subtraction went negative.
  assign rem_shift = {rem_q, acc_q[31]};
  assign rem_diff  = rem_shift - {1'b0, mcand_q};

  // Sign fix-up; a zero divisor leaves rem = |A|, so the dividend sign rule restores A in HI.
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  assign stall_execute = reset_n && (start || (state_q == StMul) || (state_q == StDiv));
  assign busy          = (state_q != StIdle);

  assign HI_register_read_data = hi_q;
  assign LO_register_read_data = lo_q;

  // Next-state logic: operation launch, iteration steps, fix-up and MTHI/MTLO writes.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d     = {32'd0, is_mul_op ? abs_b : abs_a};
          mcand_d   = is_mul_op ? abs_a : abs_b;
          rem_d     = 32'd0;
          cnt_d     = 5'd0;
          neg_res_d = is_signed_op && (src_A_execute[31] ^ src_B_execute[31]);
          neg_rem_d = is_signed_op && src_A_execute[31];
          div0_d    = (src_B_execute == 32'd0);
          is_div_d  = is_div_op;
          state_d   = is_mul_op ? StMul : StDiv;
        end else if ((ALU_function_execute == FnMthi) && HI_register_write_execute &&
                     !LO_register_write_execute) begin
          hi_d = src_A_execute;
        end else if ((ALU_function_execute == FnMtlo) && LO_register_write_execute &&
                     !HI_register_write_execute) begin
          lo_d = src_A_execute;
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) state_d = StFix;
      end
      StDiv: begin
        rem_d = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
        acc_d = {acc_q[63:32], acc_q[30:0], ~rem_diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 32'd0;
      rem_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
    end
  end

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Directed bench for hi_lo_multiply_divide_unit: hand-computed HI/LO results, stall length,
// MTHI/MTLO timing, ignored inputs, asynchronous reset mid-operation and back-to-back ops.
module tb_hi_lo_multiply_divide_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  funct;
  logic        hi_we, lo_we;
  logic [31:0] src_a, src_b;
  logic        stall_execute, busy;
  logic [31:0] hi_rd, lo_rd;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  hi_lo_multiply_divide_unit #(.ITERATIONS(32)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .ALU_function_execute      (funct),
    .HI_register_write_execute (hi_we),
    .LO_register_write_execute (lo_we),
    .src_A_execute             (src_a),
    .src_B_execute             (src_b),
    .stall_execute             (stall_execute),
    .busy                      (busy),
    .HI_register_read_data     (hi_rd),
    .LO_register_read_data     (lo_rd)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic hw, input logic lw,
                       input logic [31:0] a, input logic [31:0] b);
    funct = f;
    hi_we = hw;
    lo_we = lw;
    src_a = a;
    src_b = b;
  endtask

  // Called at a negedge: presents the op and holds it, counting stall cycles until FIX.
  task automatic op_run(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    int n = 0;
    drive(f, 1'b1, 1'b1, a, b);
    #1;
    while (stall_execute && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, " stall cycles"}, 64'(n), 64'd33);
    check_eq({tag, " busy in fix"}, 64'(busy), 64'd1);
    check_eq({tag, " hi held in fix"}, 64'(hi_rd), 64'(m_hi));
    check_eq({tag, " lo held in fix"}, 64'(lo_rd), 64'(m_lo));
  endtask

  // Next cycle after FIX: result must be visible; optionally drop the request.
  task automatic op_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit go_idle);
    @(negedge clk);
    check_eq({tag, " hi"}, 64'(hi_rd), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo_rd), 64'(exp_lo));
    m_hi = exp_hi;
    m_lo = exp_lo;
    if (go_idle) begin
      drive(6'h00, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check_eq({tag, " busy after"}, 64'(busy), 64'd0);
      check_eq({tag, " stall after"}, 64'(stall_execute), 64'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(6'h00, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset stall", 64'(stall_execute), 64'd0);
    check_eq("reset hi", 64'(hi_rd), 64'd0);
    check_eq("reset lo", 64'(lo_rd), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    op_run("multu ones", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_done("multu ones", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);

    @(negedge clk);
    op_run("mult -3x7", 6'h18, 32'hFFFF_FFFD, 32'd7);
    op_done("mult -3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

    @(negedge clk);
    op_run("mult min*min", 6'h18, 32'h8000_0000, 32'h8000_0000);
    op_done("mult min*min", 32'h4000_0000, 32'h0000_0000, 1'b1);

    @(negedge clk);
    op_run("div -7/2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    op_done("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    @(negedge clk);
    op_run("divu 100/7", 6'h1B, 32'd100, 32'd7);
    op_done("divu 100/7", 32'h0000_0002, 32'h0000_000E, 1'b1);

    @(negedge clk);
    op_run("divu by 0", 6'h1B, 32'h0000_1234, 32'd0);
    op_done("divu by 0", 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

    @(negedge clk);
    op_run("div -5 by 0", 6'h1A, 32'hFFFF_FFFB, 32'd0);
    op_done("div -5 by 0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    @(negedge clk);
    op_run("div min/-1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    op_done("div min/-1", 32'h0000_0000, 32'h8000_0000, 1'b1);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    drive(6'h11, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
    #1;
    check_eq("mthi stall", 64'(stall_execute), 64'd0);
    @(negedge clk);
    check_eq("mthi hi", 64'(hi_rd), 64'hDEAD_BEEF);
    check_eq("mthi lo kept", 64'(lo_rd), 64'(m_lo));
    drive(6'h13, 1'b0, 1'b1, 32'h0000_1234, 32'd0);
    #1;
    check_eq("mtlo stall", 64'(stall_execute), 64'd0);
    @(negedge clk);
    check_eq("mtlo lo", 64'(lo_rd), 64'h0000_1234);
    check_eq("mtlo hi kept", 64'(hi_rd), 64'hDEAD_BEEF);
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'h0000_1234;

    // MULT funct with only HI write must be ignored.
    drive(6'h18, 1'b1, 1'b0, 32'd9, 32'd9);
    #1;
    check_eq("ignored stall", 64'(stall_execute), 64'd0);
    @(negedge clk);
    check_eq("ignored busy", 64'(busy), 64'd0);
    check_eq("ignored hi", 64'(hi_rd), 64'(m_hi));
    check_eq("ignored lo", 64'(lo_rd), 64'(m_lo));

    // Reset during MULT iteration 10.
    drive(6'h18, 1'b1, 1'b1, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    #1;
    check_eq("pre-reset busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("midreset busy", 64'(busy), 64'd0);
    check_eq("midreset stall", 64'(stall_execute), 64'd0);
    check_eq("midreset hi", 64'(hi_rd), 64'd0);
    check_eq("midreset lo", 64'(lo_rd), 64'd0);
    drive(6'h00, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Back-to-back: DIVU presented in the cycle right after the MULTU FIX.
    op_run("b2b multu 3x5", 6'h19, 32'd3, 32'd5);
    op_done("b2b multu 3x5", 32'd0, 32'd15, 1'b0);
    op_run("b2b divu 17/5", 6'h1B, 32'd17, 32'd5);
    op_done("b2b divu 17/5", 32'd2, 32'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hi_lo_multiply_divide_unit.md
# hi_lo_multiply_divide_unit

Execute-stage consumer of the Decode→Execute pipeline register's HI/LO control group and operand outputs. It performs iterative MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO, and owns the architectural HI and LO registers. While an iterative operation runs, it drives `stall_execute` back to the hazard logic, which holds the Decode→Execute register and the upstream stages.

## Interface
Parameters:
- `ITERATIONS`, 32: number of shift/add or shift/subtract cycles. Fixed to the operand width; changing it is unsupported.

Ports:
- `clk`  in  1  Sole clock, rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `ALU_function_execute`  in  6  Funct code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO.
- `HI_register_write_execute`  in  1  HI write request.
- `LO_register_write_execute`  in  1  LO write request.
- `src_A_execute`  in  32  rs operand / dividend / MTHI-MTLO data.
- `src_B_execute`  in  32  rt operand / divisor.
- `stall_execute`  out  1  Hold request to the hazard logic.
- `busy`  out  1  Unit not in IDLE.
- `HI_register_read_data`  out  32  Registered HI.
- `LO_register_read_data`  out  32  Registered LO.

## Operation
- **States:** IDLE, MUL, DIV, FIX. The iteration counter is 5 bits wide.
- **Start condition:** state is IDLE, both HI and LO write requests are 1, and funct is 0x18–0x1B.
  - Operand magnitudes are captured; signed funct uses two's-complement absolute values.
  - Result sign flags are captured, and the counter is cleared.
  - Next state is MUL (0x18/0x19) or DIV (0x1A/0x1B).
- **MUL:** radix-2 shift-add over the 64-bit accumulator, one bit per cycle. After counter value 31, go to FIX.
- **DIV:** restoring division, one quotient bit per cycle, with a 33-bit partial remainder. After counter value 31, go to FIX.
- **FIX state:** apply signs, write HI/LO at the closing edge, then go to IDLE.
  - MULT: the 64-bit product is negated if the operand signs differ; HI = [63:32], LO = [31:0].
  - DIV: the quotient (LO) is negated if the operand signs differ. The remainder (HI) takes the sign of the dividend.
  - Unsigned funct: no sign adjustment.
- **Divide by zero:** LO = 0xFFFF_FFFF and HI = src_A as captured, for both signed and unsigned. No trap is raised.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** LO = 0x8000_0000, HI = 0.
- **MTHI / MTLO:** only in IDLE.
  - funct 0x11 with HI write = 1 and LO write = 0: HI ← src_A at the next edge.
  - funct 0x13 with LO write = 1 and HI write = 0: LO ← src_A at the next edge.
  - No stall is raised.
- **Ignored inputs:** any other combination of funct and write requests in IDLE leaves HI, LO and state unchanged. Inputs are also ignored in any non-IDLE state; the pipeline is held, so they repeat the in-flight instruction.
- **`stall_execute`:** combinational. It is 1 when (IDLE and start condition) or state is MUL or DIV. It is 0 in FIX, so the instruction leaves Execute on the FIX closing edge. Because state returns to IDLE on that edge, the unit does not retrigger.
- **`busy`:** equals (state ≠ IDLE).

## Timing
- **Reset (reset_n low, asynchronous):**
  - state = IDLE; HI = 0, LO = 0; counter = 0; internal accumulators = 0.
  - `busy` = 0. `stall_execute` is forced to 0 while reset_n is low.
- **Reset mid-operation:** aborts the operation. HI/LO are reset to 0, not left at their old values. After release the unit is IDLE and accepts a start on the first cycle.
- **Multicycle timeline:** start is sampled in cycle 0.
  - Cycles 1–32: MUL/DIV iterations.
  - Cycle 33: FIX.
  - New HI/LO are visible from cycle 34.
  - `stall_execute` is high for cycles 0–32, i.e. 33 cycles. Total occupancy of Execute is 34 cycles.
- **MTHI/MTLO:** the written value is visible on the read port in the following cycle. An MFHI/MFLO in the next Execute cycle reads the new value.
- **Back-to-back:** a second MULT/DIV presented in cycle 34 starts immediately; no idle gap is required.

## Test plan
- **MULTU, all ones:** MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001. `stall_execute` is high for exactly 33 cycles and HI/LO update at cycle 34.
- **MULT with mixed signs:** MULT 0xFFFF_FFFD (−3) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB. Then MULT 0x8000_0000 × 0x8000_0000 → HI = 0x4000_0000, LO = 0.
- **DIV and DIVU:**
  - DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
  - DIVU 100 / 7 → LO = 0x0000_000E, HI = 0x0000_0002.
- **Divide corner cases:**
  - DIVU 0x1234 / 0 → LO = 0xFFFF_FFFF, HI = 0x0000_1234.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- **MTHI/MTLO and ignored inputs:**
  - MTHI 0xDEAD_BEEF, then MTLO 0x0000_1234 on consecutive cycles. HI updates one cycle after the first, LO one cycle after the second, with `stall_execute` = 0 throughout.
  - Funct 0x18 with only the HI write asserted → no change to HI, LO or state.
- **Reset mid-operation and back-to-back:**
  - Drive reset_n low during MULT iteration 10 → `busy` = 0, `stall_execute` = 0 and HI = LO = 0 immediately, without waiting for a clock edge.
  - After release, MULTU 3 × 5 followed directly by DIVU 17 / 5 → first result HI = 0, LO = 15. Second result LO = 3, HI = 2. The second operation starts in the cycle after FIX.
